// File: rtl/freq_meter_pkg.sv
// Shared definitions for the frequency meter: default clock rate and FSM state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package freq_meter_pkg;

  // Default clk_in frequency in Hz; a 1 s window uses this many gate cycles.
  localparam int unsigned BASE_FREQ_DEF = 50_000_000;

  // Measurement FSM: idle, counting window open, one-cycle result publish.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_DONE    = 2'd2
  } fm_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Brings an asynchronous signal into clk_in through two flops and flags its rising edges.
// Latency: edge pulse is high in the third clk_in cycle after the input transition.
// Backpressure: none; one pulse per observed rising edge, never stalled.
//
// Ports:
//   clk_in      system clock
//   rst_a_n     asynchronous active-low reset, clears every flop
//   sig_in      asynchronous input signal
//   edge_pulse  one-cycle pulse per synchronized rising edge
module sync_edge_det (
  input  logic clk_in,
  input  logic rst_a_n,
  input  logic sig_in,
  output logic edge_pulse
);

  logic meta_q;    // first stage, may go metastable
  logic sync_q;    // second stage, safe to use
  logic sync_d_q;  // previous synchronized value for edge detection

  always_ff @(posedge clk_in or negedge rst_a_n) begin
    if (!rst_a_n) begin
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      sync_d_q <= 1'b0;
    end else begin
      meta_q   <= sig_in;
      sync_q   <= meta_q;
      sync_d_q <= sync_q;
    end
  end

  assign edge_pulse = sync_q & ~sync_d_q;

endmodule

// File: rtl/freq_meter.sv
// Counts rising edges of sig_in over a GATE_CYCLES-long window and publishes the count.
// Latency: done asserts GATE_CYCLES+1 cycles after the start cycle; one DONE cycle between windows.
// Backpressure: none; start is ignored unless idle, results simply hold until the next done.
//
// Ports:
//   clk_in, rst_a_n  clock and asynchronous active-low reset
//   sig_in           measured signal (asynchronous to clk_in)
//   start            one-cycle request to open a window (only honoured in IDLE)
//   cont             continuous mode, sampled in the DONE cycle
//   busy             high while a window is open
//   done             one-cycle pulse when freq_count/ovf update
//   freq_count, ovf  edge count of the last window and its saturation flag
//   period_count     (only with FREQ_METER_PERIOD_EN) clk_in cycles between the last two
//                    edges of the last window, 0 if fewer than two edges
//
// Build option: define FREQ_METER_PERIOD_EN to add the period_count output and its counters.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int unsigned BASE_FREQ   = BASE_FREQ_DEF,
  parameter int unsigned GATE_CYCLES = 50_000_000,
  parameter int unsigned CNT_W       = 26
) (
  input  logic             clk_in,
  input  logic             rst_a_n,
  input  logic             sig_in,
  input  logic             start,
  input  logic             cont,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] freq_count,
`ifdef FREQ_METER_PERIOD_EN
  output logic [CNT_W-1:0] period_count,
`endif
  output logic             ovf
);

  localparam int unsigned      GATE_W    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  // A zero-length window or zero clock rate makes the gate compare meaningless.
  if (GATE_CYCLES == 0 || BASE_FREQ == 0) begin : g_cfg_err
    $error("freq_meter: GATE_CYCLES and BASE_FREQ must be non-zero");
  end

  fm_state_t         state_q;
  fm_state_t         state_d;
  logic              edge_pulse;
  logic [GATE_W-1:0] gate_cnt;
  logic [CNT_W-1:0]  edge_cnt;
  logic [CNT_W-1:0]  edge_cnt_nxt;
  logic              ovf_int;
  logic              ovf_nxt;
  logic              gate_last;

  sync_edge_det u_sync_edge_det (
    .clk_in     (clk_in),
    .rst_a_n    (rst_a_n),
    .sig_in     (sig_in),
    .edge_pulse (edge_pulse)
  );

  assign gate_last = (state_q == ST_MEASURE) && (gate_cnt == GATE_LAST);

  // ---------------- FSM ----------------
  always_ff @(posedge clk_in or negedge rst_a_n) begin
    if (!rst_a_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start)     state_d = ST_MEASURE;
      ST_MEASURE: if (gate_last) state_d = ST_DONE;
      ST_DONE:    state_d = cont ? ST_MEASURE : ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == ST_MEASURE);
    done = (state_q == ST_DONE);
  end

  // ---------------- window counters ----------------
  // Saturating edge count; ovf_int marks an edge that arrived with the counter already full.
  always_comb begin
    edge_cnt_nxt = edge_cnt;
    ovf_nxt      = ovf_int;
    if (edge_pulse) begin
      if (edge_cnt == CNT_MAX) ovf_nxt      = 1'b1;
      else                     edge_cnt_nxt = edge_cnt + 1'b1;
    end
  end

  // Counters are held at zero outside MEASURE, so every window starts clean
  // whether it was entered from IDLE or straight from DONE.
  always_ff @(posedge clk_in or negedge rst_a_n) begin
    if (!rst_a_n) begin
      gate_cnt <= '0;
      edge_cnt <= '0;
      ovf_int  <= 1'b0;
    end else if (state_q != ST_MEASURE) begin
      gate_cnt <= '0;
      edge_cnt <= '0;
      ovf_int  <= 1'b0;
    end else begin
      gate_cnt <= gate_cnt + 1'b1;
      edge_cnt <= edge_cnt_nxt;
      ovf_int  <= ovf_nxt;
    end
  end

  // Results are captured on the last MEASURE edge using the next-state values,
  // so an edge in the final window cycle is included and done sees fresh data.
  always_ff @(posedge clk_in or negedge rst_a_n) begin
    if (!rst_a_n) begin
      freq_count <= '0;
      ovf        <= 1'b0;
    end else if (gate_last) begin
      freq_count <= edge_cnt_nxt;
      ovf        <= ovf_nxt;
    end
  end

`ifdef FREQ_METER_PERIOD_EN
  // ---------------- period measurement ----------------
  logic [CNT_W-1:0] per_run;       // cycles since the previous edge, minus one
  logic [CNT_W-1:0] per_run_inc;
  logic [CNT_W-1:0] per_last;      // spacing of the two most recent edges
  logic [CNT_W-1:0] per_run_nxt;
  logic [CNT_W-1:0] per_last_nxt;

  assign per_run_inc = (per_run == CNT_MAX) ? per_run : per_run + 1'b1;

  always_comb begin
    per_run_nxt  = per_run_inc;
    per_last_nxt = per_last;
    if (edge_pulse) begin
      per_run_nxt = '0;
      // A non-zero edge count means a previous edge exists in this window.
      if (edge_cnt != '0) per_last_nxt = per_run_inc;
    end
  end

  always_ff @(posedge clk_in or negedge rst_a_n) begin
    if (!rst_a_n) begin
      per_run  <= '0;
      per_last <= '0;
    end else if (state_q != ST_MEASURE) begin
      per_run  <= '0;
      per_last <= '0;
    end else begin
      per_run  <= per_run_nxt;
      per_last <= per_last_nxt;
    end
  end

  always_ff @(posedge clk_in or negedge rst_a_n) begin
    if (!rst_a_n)       period_count <= '0;
    else if (gate_last) period_count <= per_last_nxt;
  end
`endif

endmodule
